monitor_semaforo: RTL and testbench

MONITOR_SEMAFORO -- requirements
Module: monitor_semaforo

---
 rtl/monitor_semaforo.sv | 147 ++++++++++++++
 tb/tb_monitor_semaforo.sv | 133 +++++++++++++
 2 files changed

// File: rtl/monitor_semaforo.sv
// Two-light traffic signal monitor: sticky first-error code (illegal/transition/conflict/timing), 1-cycle latency, no backpressure.
// Define MONITOR_TIMING_EN to add per-light duration counters and the timing (code 4) check.
module monitor_semaforo #(
  parameter logic [7:0] T_VERDE   = 8'd1,
  parameter logic [7:0] T_AMARELO = 8'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] ciclos_a
);

  localparam logic [2:0] VERDE    = 3'b001;
  localparam logic [2:0] AMARELO  = 3'b010;
  localparam logic [2:0] VERMELHO = 3'b100;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_ILEGAL   = 3'd1;
  localparam logic [2:0] E_TRANSICAO = 3'd2;
  localparam logic [2:0] E_CONFLITO = 3'd3;
  localparam logic [2:0] E_TEMPO    = 3'd4;

  function automatic logic is_legal(input logic [2:0] s);
    return (s == VERDE) || (s == AMARELO) || (s == VERMELHO);
  endfunction

  function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
    return (c == p) ||
           (p == VERDE    && c == AMARELO)  ||
           (p == AMARELO  && c == VERMELHO) ||
           (p == VERMELHO && c == VERDE);
  endfunction

  logic [2:0] prev_a_q, prev_a_d;
  logic [2:0] prev_b_q, prev_b_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic [2:0] code_q, code_d;
  logic [7:0] ciclos_q, ciclos_d;

  logic       a_ok, b_ok, pa_ok, pb_ok;
  logic       c_ilegal, c_trans, c_confl, c_tempo;
  logic [2:0] code_now;

`ifdef MONITOR_TIMING_EN
  logic [7:0] dur_a_q, dur_a_d;
  logic [7:0] dur_b_q, dur_b_d;

  // Only the departure from a timed state is judged; holding or leaving red is free.
  function automatic logic time_ok(input logic [2:0] p, input logic [2:0] c,
                                   input logic [7:0] dur);
    if (c == p)       return 1'b1;
    if (p == AMARELO) return dur == T_AMARELO;
    if (p == VERDE)   return dur >= T_VERDE;
    return 1'b1;
  endfunction

  function automatic logic [7:0] dur_next(input logic [2:0] p, input logic [2:0] c,
                                          input logic [7:0] dur);
    if (c != p)        return 8'd1;
    if (dur == 8'hFF)  return 8'hFF;
    return dur + 8'd1;
  endfunction
`else
  logic unused_timing_cfg;
  assign unused_timing_cfg = ^{T_VERDE, T_AMARELO};
`endif

  always_comb begin
    a_ok  = is_legal(A);
    b_ok  = is_legal(B);
    pa_ok = is_legal(prev_a_q);
    pb_ok = is_legal(prev_b_q);

    c_ilegal = !a_ok || !b_ok;
    c_trans  = valid_q && ((a_ok && pa_ok && !step_ok(prev_a_q, A)) ||
                           (b_ok && pb_ok && !step_ok(prev_b_q, B)));
    c_confl  = (A != VERMELHO) && (B != VERMELHO);
`ifdef MONITOR_TIMING_EN
    c_tempo  = valid_q && ((a_ok && pa_ok && !time_ok(prev_a_q, A, dur_a_q)) ||
                           (b_ok && pb_ok && !time_ok(prev_b_q, B, dur_b_q)));
`else
    c_tempo  = 1'b0;
`endif

    if (c_ilegal)      code_now = E_ILEGAL;
    else if (c_trans)  code_now = E_TRANSICAO;
    else if (c_confl)  code_now = E_CONFLITO;
    else if (c_tempo)  code_now = E_TEMPO;
    else               code_now = E_NONE;

    err_d  = err_q;
    code_d = code_q;
    if (!err_q && code_now != E_NONE) begin
      err_d  = 1'b1;
      code_d = code_now;
    end

    // An illegal sample leaves that light's history untouched.
    prev_a_d = a_ok ? A : prev_a_q;
    prev_b_d = b_ok ? B : prev_b_q;
    valid_d  = 1'b1;

    ciclos_d = ciclos_q;
    if (valid_q && prev_a_q == VERMELHO && A == VERDE)
      ciclos_d = ciclos_q + 8'd1;

`ifdef MONITOR_TIMING_EN
    dur_a_d = a_ok ? dur_next(prev_a_q, A, dur_a_q) : dur_a_q;
    dur_b_d = b_ok ? dur_next(prev_b_q, B, dur_b_q) : dur_b_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_a_q <= 3'd0;
      prev_b_q <= 3'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= E_NONE;
      ciclos_q <= 8'd0;
`ifdef MONITOR_TIMING_EN
      dur_a_q  <= 8'd0;
      dur_b_q  <= 8'd0;
`endif
    end else begin
      prev_a_q <= prev_a_d;
      prev_b_q <= prev_b_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
      ciclos_q <= ciclos_d;
`ifdef MONITOR_TIMING_EN
      dur_a_q  <= dur_a_d;
      dur_b_q  <= dur_b_d;
`endif
    end
  end

  assign err      = err_q;
  assign err_code = code_q;
  assign ciclos_a = ciclos_q;

endmodule

// File: tb/tb_monitor_semaforo.sv
// Directed bench for monitor_semaforo: legal cycling, each error code, priority, wrap and async reset.
module tb_monitor_semaforo;

  localparam logic [2:0] V = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] a_s = R;
  logic [2:0] b_s = V;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] ciclos_a;

  int ncmp = 0;
  int nerr = 0;

  // One full legal cycle: B runs green/yellow while A is red, then A runs green/yellow.
  logic [2:0] pat_a [8] = '{R, R, R, R, V, Y, Y, Y};
  logic [2:0] pat_b [8] = '{V, Y, Y, Y, R, R, R, R};

  monitor_semaforo dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a_s),
    .B        (b_s),
    .err      (err),
    .err_code (err_code),
    .ciclos_a (ciclos_a)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b);
    a_s = a;
    b_s = b;
    @(posedge clk);
    #1;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) drive(pat_a[i % 8], pat_b[i % 8]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_err",  {7'd0, err}, 8'd0);
    chk("rst_code", {5'd0, err_code}, 8'd0);
    chk("rst_cyc",  ciclos_a, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    run_steps(24);
    chk("legal3_err", {7'd0, err}, 8'd0);
    chk("legal3_cyc", ciclos_a, 8'd3);

    drive(3'b011, R);
    chk("ileg_err",  {7'd0, err}, 8'd1);
    chk("ileg_code", {5'd0, err_code}, 8'd1);
    run_steps(20);
    chk("sticky_err",  {7'd0, err}, 8'd1);
    chk("sticky_code", {5'd0, err_code}, 8'd1);
    chk("count_after_err", ciclos_a, 8'd5);

    do_reset();
    drive(V, R);
    chk("pre_trans_err", {7'd0, err}, 8'd0);
    drive(R, R);
    chk("trans_err",  {7'd0, err}, 8'd1);
    chk("trans_code", {5'd0, err_code}, 8'd2);

    do_reset();
    drive(V, Y);
    chk("confl_code", {5'd0, err_code}, 8'd3);

    do_reset();
    drive(3'b000, V);
    chk("prio_code", {5'd0, err_code}, 8'd1);

    do_reset();
    drive(V, R);
    drive(Y, R);
    drive(Y, R);
    chk("pre_tempo_err", {7'd0, err}, 8'd0);
    drive(R, R);
`ifdef MONITOR_TIMING_EN
    chk("tempo_err",  {7'd0, err}, 8'd1);
    chk("tempo_code", {5'd0, err_code}, 8'd4);
`else
    chk("tempo_off_err",  {7'd0, err}, 8'd0);
    chk("tempo_off_code", {5'd0, err_code}, 8'd0);
`endif

    do_reset();
    run_steps(255 * 8);
    chk("cyc255", ciclos_a, 8'd255);
    run_steps(8);
    chk("cyc_wrap", ciclos_a, 8'd0);
    chk("wrap_err", {7'd0, err}, 8'd0);

    drive(3'b111, R);
    chk("pre_async_err", {7'd0, err}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_err",  {7'd0, err}, 8'd0);
    chk("async_code", {5'd0, err_code}, 8'd0);
    chk("async_cyc",  ciclos_a, 8'd0);
    #1;
    rst = 1'b0;
    drive(Y, R);
    chk("first_amarelo_err", {7'd0, err}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
